// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Filter bounds are used only when UART_TX_FILTER_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic [UART_DATA_W-1:0] UART_PRINT_LO = 8'h21;
  localparam logic [UART_DATA_W-1:0] UART_PRINT_HI = 8'h7A;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side and status signals of the buffered UART transmitter.
// master: the producer writing bytes; slave: the transmitter itself.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);

  logic [UART_DATA_W-1:0] din;
  logic                   we;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   drop;
  logic                   busy;
  logic                   tx;

  modport master (
    output din,
    output we,
    input  full,
    input  count,
    input  drop,
    input  busy,
    input  tx
  );

  modport slave (
    input  din,
    input  we,
    output full,
    output count,
    output drop,
    output busy,
    output tx
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous DEPTH x 8 FIFO; pointers carry an extra wrap bit so full and
// empty fall out of a plain pointer compare. Push when full / pop when empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] din,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]            wr_ptr_q;
  logic [AW:0]            rd_ptr_q;
  logic                   do_push;
  logic                   do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == FullCount);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO-queued bytes serialised LSB first on tx.
// Optional UART_TX_FILTER_EN stores only printable bytes 0x21..0x7A.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned Div   = uart_div(CLK_HZ, BAUD);
  localparam int unsigned BaudW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(Div - 1);

  uart_state_e            state_q;
  logic [BaudW-1:0]       baud_q;
  logic [2:0]             bit_idx_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   drop_q;

  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   baud_end;

`ifdef UART_TX_FILTER_EN
  assign accept = (bus.din >= UART_PRINT_LO) && (bus.din <= UART_PRINT_HI);
`else
  assign accept = 1'b1;
`endif

  assign push     = bus.we & accept;
  assign baud_end = (baud_q == BaudMax);
  // Pop on leaving IDLE or at the end of STOP, i.e. on every entry into START.
  assign pop      = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & baud_end));

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (bus.count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      // Filtered bytes are silently ignored, never reported as drops.
      drop_q <= push & fifo_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_dout;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.full = fifo_full;
  assign bus.drop = drop_q;
  assign bus.busy = busy_q;
  assign bus.tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DIV=10, DEPTH=4): a line monitor decodes each
// frame on tx and checks it against bytes queued in a scoreboard at write time.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   t1;
  int   n;
  int   quiet_bad;

  logic [7:0] sb[$];

  logic       mon_active;
  int         mon_cnt;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_HZ (1000),
    .BAUD   (100),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic bit accepted(input logic [7:0] b);
`ifdef UART_TX_FILTER_EN
    return (b >= 8'h21) && (b <= 8'h7A);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    bus.din = b;
    bus.we  = 1'b1;
    if (accepted(b)) sb.push_back(b);
  endtask

  task automatic wait_idle(input int bound);
    n = 0;
    while (bus.busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Line monitor: start detected at cnt 0, mid-bit samples at 15,25..85, stop at 95.
  initial mon_active = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (bus.tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) check("start_bit", bus.tx, 1'b0);
      if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
        mon_byte[(mon_cnt - 15) / 10] = bus.tx;
      if (mon_cnt == 95) check("stop_bit", bus.tx, 1'b1);
      if (mon_cnt == 99) begin
        mon_active = 1'b0;
        check("frame_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("frame_byte", mon_byte, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  exp_cnt  [7] = '{1, 1, 2, 3, 4, 4, 4};
  bit  exp_full [7] = '{0, 0, 0, 0, 1, 1, 1};
  bit  exp_drop [7] = '{0, 0, 0, 0, 0, 1, 1};
  logic [7:0] filt_bytes [3] = '{8'h20, 8'h7B, 8'h21};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.we      = 1'b0;
    bus.din     = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_drop", bus.drop, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start bit one cycle after the write edge, 100-cycle frame
    drive(8'h41);
    @(negedge clk);
    bus.we = 1'b0;
    check("single_tx_e0", bus.tx, 1'b1);
    check("single_count_e0", bus.count, 1);
    @(negedge clk);
    check("single_tx_e1", bus.tx, 1'b0);
    check("single_busy_e1", bus.busy, 1'b1);
    check("single_count_e1", bus.count, 0);
    t1 = cyc;
    wait_idle(300);
    check("single_len", cyc - t1, 100);
    check("single_sb_empty", sb.size(), 0);

    // Overflow: 0x31..0x37 back to back, 0x36/0x37 dropped
    repeat (5) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        check("ovf_count", bus.count, exp_cnt[k-1]);
        check("ovf_full", bus.full, exp_full[k-1]);
        check("ovf_drop", bus.drop, exp_drop[k-1]);
      end
      if (k == 2) t1 = cyc;
      if (k < 5) begin
        drive(8'h31 + 8'(k));
      end else if (k < 7) begin
        bus.din = 8'h31 + 8'(k);
        bus.we  = 1'b1;
      end else begin
        bus.we = 1'b0;
      end
      @(negedge clk);
    end
    check("ovf_drop_end", bus.drop, 1'b0);
    check("ovf_full_end", bus.full, 1'b1);
    wait_idle(1000);
    check("ovf_total_len", cyc - t1, 500);
    check("ovf_sb_empty", sb.size(), 0);

    // Write landing on the STOP-end pop: count holds, next frame starts at once
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) t1 = cyc;
      drive(8'h50 + 8'(k));
      @(negedge clk);
    end
    bus.we = 1'b0;
    check("wp_count_pre", bus.count, 2);
    while (cyc < t1 + 99) @(negedge clk);
    drive(8'h53);
    @(negedge clk);
    bus.we = 1'b0;
    check("wp_count", bus.count, 2);
    check("wp_tx_start", bus.tx, 1'b0);
    check("wp_busy", bus.busy, 1'b1);
    wait_idle(2000);
    check("wp_sb_empty", sb.size(), 0);

    // Byte filter (active only with UART_TX_FILTER_EN)
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(filt_bytes[k]);
      @(negedge clk);
      check("filt_drop", bus.drop, 1'b0);
    end
    bus.we = 1'b0;
    @(negedge clk);
    check("filt_drop_end", bus.drop, 1'b0);
    wait_idle(2000);
    check("filt_sb_empty", sb.size(), 0);

    // Reset during data bit 3 discards everything; no frame afterwards
    repeat (5) @(negedge clk);
    drive(8'h5A);
    @(negedge clk);
    drive(8'h33);
    @(negedge clk);
    bus.we = 1'b0;
    t1 = cyc;
    while (cyc < t1 + 45) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", bus.tx, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_count", bus.count, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) quiet_bad++;
    end
    check("post_rst_quiet", quiet_bad, 0);
    check("post_rst_count", bus.count, 0);

    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
